frame_reader: RTL and testbench

FRAME_READER -- requirements
Module: frame_reader

---
 rtl/frame_reader.sv | 141 ++++++++++++++
 tb/tb_frame_reader.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_reader.sv
// Frame readout engine: streams a row-major frame out of a pixel buffer through a
// 2-entry output buffer with valid/ready handshake and line/frame markers.
module frame_reader #(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned H_PIX   = 16,
    parameter int unsigned V_LINES = 16,
    parameter int unsigned ADDR_W  = 8
) (
    input  logic              clk,
    input  logic              erst,
    input  logic              start,
    input  logic              frame_ready,
    input  logic              pause,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_data,
    output logic [DATA_W-1:0] pix_data,
    output logic              pix_valid,
    input  logic              pix_ready,
    output logic              line_end,
    output logic              frame_end,
    output logic              busy,
    output logic              done
);

    localparam int unsigned N     = H_PIX * V_LINES;
    localparam int unsigned COL_W = (H_PIX > 1) ? $clog2(H_PIX) : 1;
    localparam int unsigned ROW_W = (V_LINES > 1) ? $clog2(V_LINES) : 1;
    localparam int unsigned CNT_W = ADDR_W + 1;

    typedef enum logic [1:0] {IDLE, READ, DONE} state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   issue_q, issue_d;
    logic [COL_W-1:0]   col_q, col_d;
    logic [ROW_W-1:0]   row_q, row_d;
    logic [ADDR_W-1:0]  addr_q;
    logic               inflight_q;
    logic [DATA_W-1:0]  buf_q [2];
    logic               rd_ptr_q, wr_ptr_q;
    logic [1:0]         count_q, count_d;

    logic       buf_nonempty, pop, pop_buf, push, last_col, last_row, can_issue;
    logic [1:0] occ;

    // Returning read data is presented directly when the buffer is empty, so a pixel
    // appears in the cycle its data arrives; it is captured only if not consumed.
    always_comb begin
        buf_nonempty = (count_q != 2'd0);
        pix_valid    = buf_nonempty | inflight_q;
        pix_data     = '0;
        if (buf_nonempty) begin
            pix_data = buf_q[rd_ptr_q];
        end else if (inflight_q) begin
            pix_data = mem_data;
        end
        last_col  = (col_q == COL_W'(H_PIX - 1));
        last_row  = (row_q == ROW_W'(V_LINES - 1));
        line_end  = pix_valid & last_col;
        frame_end = line_end & last_row;
        pop       = pix_valid & pix_ready;
        pop_buf   = pop & buf_nonempty;
        push      = inflight_q & ~(pop & ~buf_nonempty);
        occ       = count_q + {1'b0, inflight_q} - {1'b0, pop};
        can_issue = (issue_q < CNT_W'(N));
        mem_rd    = (state_q == READ) & ~pause & can_issue & (occ < 2'd2);
        mem_addr  = mem_rd ? ADDR_W'(issue_q) : addr_q;
        busy      = (state_q != IDLE);
        done      = (state_q == DONE);
        count_d   = count_q + {1'b0, push} - {1'b0, pop_buf};
    end

    always_comb begin
        state_d = state_q;
        issue_d = issue_q;
        col_d   = col_q;
        row_d   = row_q;
        if (mem_rd) begin
            issue_d = issue_q + 1'b1;
        end
        if (pop) begin
            if (last_col) begin
                col_d = '0;
                row_d = last_row ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end
        unique case (state_q)
            IDLE: begin
                if (start && frame_ready) begin
                    state_d = READ;
                    issue_d = '0;
                    col_d   = '0;
                    row_d   = '0;
                end
            end
            READ: begin
                if (pop && frame_end) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (erst) begin
            state_q    <= IDLE;
            issue_q    <= '0;
            col_q      <= '0;
            row_q      <= '0;
            addr_q     <= '0;
            inflight_q <= 1'b0;
            buf_q[0]   <= '0;
            buf_q[1]   <= '0;
            rd_ptr_q   <= 1'b0;
            wr_ptr_q   <= 1'b0;
            count_q    <= 2'd0;
        end else begin
            state_q    <= state_d;
            issue_q    <= issue_d;
            col_q      <= col_d;
            row_q      <= row_d;
            inflight_q <= mem_rd;
            count_q    <= count_d;
            if (mem_rd) begin
                addr_q <= mem_addr;
            end
            if (push) begin
                buf_q[wr_ptr_q] <= mem_data;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop_buf) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
        end
    end

endmodule

// File: tb/tb_frame_reader.sv
// Directed bench for frame_reader: a 4x2 instance for timing/corner cases and a
// default 16x16 instance driven with random downstream backpressure.
module tb_frame_reader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic       erst, start, frame_ready, pause, pix_ready;
    logic       mem_rd, pix_valid, line_end, frame_end, busy, done;
    logic [7:0] mem_addr, pix_data;
    logic [7:0] mem_data = 8'd0;

    logic       start16, pix_ready16;
    logic       mem_rd16, pix_valid16, line_end16, frame_end16, busy16, done16;
    logic [7:0] mem_addr16, pix_data16;
    logic [7:0] mem_data16 = 8'd0;

    frame_reader #(.DATA_W(8), .H_PIX(4), .V_LINES(2), .ADDR_W(8)) dut (
        .clk(clk), .erst(erst), .start(start), .frame_ready(frame_ready), .pause(pause),
        .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_data(mem_data), .pix_data(pix_data),
        .pix_valid(pix_valid), .pix_ready(pix_ready), .line_end(line_end),
        .frame_end(frame_end), .busy(busy), .done(done)
    );

    frame_reader dut16 (
        .clk(clk), .erst(erst), .start(start16), .frame_ready(1'b1), .pause(1'b0),
        .mem_rd(mem_rd16), .mem_addr(mem_addr16), .mem_data(mem_data16),
        .pix_data(pix_data16), .pix_valid(pix_valid16), .pix_ready(pix_ready16),
        .line_end(line_end16), .frame_end(frame_end16), .busy(busy16), .done(done16)
    );

    function automatic logic [7:0] img(input logic [7:0] a);
        return a * 8'd37 + 8'd5;
    endfunction

    function automatic logic [7:0] img16(input logic [7:0] a);
        return a * 8'd13 + 8'd1;
    endfunction

    // Synchronous buffer model: data valid the cycle after the read strobe
    always @(posedge clk) begin
        if (mem_rd) mem_data <= img(mem_addr);
        if (mem_rd16) mem_data16 <= img16(mem_addr16);
    end

    typedef struct {
        bit pr; bit rd; logic [7:0] addr; bit pv; logic [7:0] data;
        bit le; bit fe; bit busy; bit done;
    } vec_t;

    function automatic vec_t mk(bit pr, bit rd, logic [7:0] addr, bit pv, logic [7:0] data,
                                bit le, bit fe, bit bz, bit dn);
        vec_t v;
        v.pr = pr; v.rd = rd; v.addr = addr; v.pv = pv; v.data = data;
        v.le = le; v.fe = fe; v.busy = bz; v.done = dn;
        return v;
    endfunction

    vec_t       vecs[11];
    logic [7:0] exp_pix[8] = '{8'd5, 8'd42, 8'd79, 8'd116, 8'd153, 8'd190, 8'd227, 8'd8};
    bit         pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};

    int n_chk = 0;
    int n_pass = 0;

    logic [7:0] q_addr[$];
    logic [7:0] q_data[$];
    bit         q_le[$];
    bit         q_fe[$];
    int         n_done, iss, xfr;
    bit         prev_stall = 1'b0;
    logic [10:0] prev_out;

    logic [7:0] q16_data[$];
    int          n16_le, n16_fe, n16_done;
    bit          prev_stall16 = 1'b0;
    logic [10:0] prev_out16;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic clear_log();
        q_addr.delete(); q_data.delete(); q_le.delete(); q_fe.delete();
        n_done = 0; iss = 0; xfr = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
        if (prev_stall)
            check("stall_hold", {pix_valid, pix_data, line_end, frame_end}, prev_out);
        if (prev_stall16)
            check("stall_hold16", {pix_valid16, pix_data16, line_end16, frame_end16},
                  prev_out16);
        if (mem_rd) begin
            q_addr.push_back(mem_addr);
            iss++;
        end
        if (pix_valid && pix_ready) begin
            q_data.push_back(pix_data); q_le.push_back(line_end); q_fe.push_back(frame_end);
            xfr++;
        end
        if (done) n_done++;
        prev_stall = pix_valid && !pix_ready;
        prev_out   = {1'b1, pix_data, line_end, frame_end};
        if (pix_valid16 && pix_ready16) begin
            q16_data.push_back(pix_data16);
            if (line_end16) n16_le++;
            if (frame_end16) n16_fe++;
        end
        if (done16) n16_done++;
        prev_stall16 = pix_valid16 && !pix_ready16;
        prev_out16   = {1'b1, pix_data16, line_end16, frame_end16};
    endtask

    task automatic run_to_done(input string name, input int max_cyc);
        int k = 0;
        while (n_done == 0 && k < max_cyc) begin
            step(); start = 1'b0; sample(); k++;
        end
        check({name, "_done_once"}, n_done, 1);
    endtask

    task automatic check_frame(input string name);
        check({name, "_naddr"}, q_addr.size(), 8);
        check({name, "_npix"}, q_data.size(), 8);
        for (int i = 0; i < 8; i++) begin
            if (i < q_addr.size()) check($sformatf("%s_addr%0d", name, i), q_addr[i], i);
            if (i < q_data.size())
                check($sformatf("%s_pix%0d", name, i), {q_data[i], q_le[i], q_fe[i]},
                      {exp_pix[i], (i % 4 == 3), (i == 7)});
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        // pr, rd, addr, pv, data, le, fe, busy, done -- start sampled at edge 10
        vecs[0]  = mk(1, 1, 8'd0, 0, 8'd0,   0, 0, 1, 0);
        vecs[1]  = mk(1, 1, 8'd1, 1, 8'd5,   0, 0, 1, 0);
        vecs[2]  = mk(1, 1, 8'd2, 1, 8'd42,  0, 0, 1, 0);
        vecs[3]  = mk(1, 1, 8'd3, 1, 8'd79,  0, 0, 1, 0);
        vecs[4]  = mk(1, 1, 8'd4, 1, 8'd116, 1, 0, 1, 0);
        vecs[5]  = mk(1, 1, 8'd5, 1, 8'd153, 0, 0, 1, 0);
        vecs[6]  = mk(1, 1, 8'd6, 1, 8'd190, 0, 0, 1, 0);
        vecs[7]  = mk(1, 1, 8'd7, 1, 8'd227, 0, 0, 1, 0);
        vecs[8]  = mk(1, 0, 8'd7, 1, 8'd8,   1, 1, 1, 0);
        vecs[9]  = mk(1, 0, 8'd7, 0, 8'd0,   0, 0, 1, 1);
        vecs[10] = mk(1, 0, 8'd7, 0, 8'd0,   0, 0, 0, 0);

        erst = 1'b1; start = 1'b0; frame_ready = 1'b1; pause = 1'b0; pix_ready = 1'b1;
        start16 = 1'b0; pix_ready16 = 1'b1;
        n16_le = 0; n16_fe = 0; n16_done = 0;
        clear_log();
        repeat (3) begin step(); sample(); end
        check("reset_outs", {mem_rd, mem_addr, pix_valid, pix_data, line_end, frame_end,
                             busy, done}, 0);
        check("reset_outs16", {mem_rd16, mem_addr16, pix_valid16, pix_data16, line_end16,
                               frame_end16, busy16, done16}, 0);
        erst = 1'b0;

        // Nominal 4x2 frame, cycle-exact
        while (cyc < 9) begin step(); sample(); end
        start = 1'b1;
        for (int o = 0; o < 11; o++) begin
            step(); start = 1'b0; pix_ready = vecs[o].pr; sample();
            check($sformatf("vec%0d", o),
                  {mem_rd, mem_addr, pix_valid, pix_data, line_end, frame_end, busy, done},
                  {vecs[o].rd, vecs[o].addr, vecs[o].pv, vecs[o].data, vecs[o].le,
                   vecs[o].fe, vecs[o].busy, vecs[o].done});
        end

        // Backpressure 1,0,0,1 repeating
        clear_log();
        step(); start = 1'b1;
        for (int i = 0; i < 80 && n_done == 0; i++) begin
            step(); start = 1'b0; pix_ready = pat[i % 4]; sample();
            check("outstanding_le2", (iss - xfr) <= 2, 1);
        end
        check("bp_done_once", n_done, 1);
        check_frame("bp");
        pix_ready = 1'b1;

        // Pause for 5 cycles after address 2
        clear_log();
        step(); start = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step(); start = 1'b0; sample();
            if (mem_rd && mem_addr == 8'd2) break;
        end
        check("pause_saw_addr2", {mem_rd, mem_addr}, {1'b1, 8'd2});
        for (int p = 0; p < 5; p++) begin
            step(); pause = 1'b1; sample();
            check("pause_no_rd", mem_rd, 0);
            if (p == 4) check("pause_drained", pix_valid, 0);
        end
        step(); pause = 1'b0; sample();
        check("resume_addr3", {mem_rd, mem_addr}, {1'b1, 8'd3});
        run_to_done("pause", 40);
        check_frame("pause");

        // start ignored without frame_ready, and during READ
        step(); frame_ready = 1'b0; start = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step(); start = 1'b0; sample();
            check("nofr_idle", {busy, mem_rd}, 0);
        end
        frame_ready = 1'b1;
        clear_log();
        step(); start = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step(); start = (i == 2); sample();
        end
        run_to_done("restart", 40);
        check_frame("restart");
        step(); sample();
        check("restart_idle", {busy, mem_rd}, 0);

        // Reset after 3 transfers
        clear_log();
        step(); start = 1'b1;
        for (int i = 0; i < 20 && xfr < 3; i++) begin
            step(); start = 1'b0; sample();
        end
        check("rst_pre_xfr3", xfr, 3);
        step(); erst = 1'b1; sample();
        step(); erst = 1'b0; sample();
        check("rst_mid_outs", {mem_rd, mem_addr, pix_valid, pix_data, line_end, frame_end,
                               busy, done}, 0);
        clear_log();
        step(); start = 1'b1;
        step(); start = 1'b0; sample();
        check("rst_fresh_addr0", {mem_rd, mem_addr}, {1'b1, 8'd0});
        run_to_done("rst_fresh", 40);
        check_frame("rst_fresh");

        // Default 16x16 frame with random backpressure
        q16_data.delete(); n16_le = 0; n16_fe = 0; n16_done = 0;
        step(); start16 = 1'b1;
        for (int i = 0; i < 3000 && n16_done == 0; i++) begin
            step(); start16 = 1'b0; pix_ready16 = ($urandom_range(0, 3) != 0); sample();
        end
        pix_ready16 = 1'b1;
        repeat (5) begin step(); sample(); end
        check("f16_npix", q16_data.size(), 256);
        for (int i = 0; i < 256; i++) begin
            if (i < q16_data.size())
                check($sformatf("f16_pix%0d", i), q16_data[i], img16(8'(i)));
        end
        check("f16_line_end", n16_le, 16);
        check("f16_frame_end", n16_fe, 1);
        check("f16_done", n16_done, 1);
        check("f16_idle", busy16, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
